// File: rtl/fifo_gearbox.sv
// fifo_gearbox: lane-based first-word-fall-through FIFO converting DINWIDTH writes to DOUTWIDTH reads.
// Define FIFO_GEARBOX_ERR_FLAGS_EN to build the sticky overflow/underflow flags; otherwise they are tied 0.
module fifo_gearbox #(
  parameter int DINWIDTH         = 64,
  parameter int DOUTWIDTH        = 16,
  parameter int DEPTH            = 128,
  parameter int PROG_FULL_THRESH = DEPTH * DINWIDTH /
                                   ((DINWIDTH < DOUTWIDTH) ? DINWIDTH : DOUTWIDTH) - 8,
  localparam int MINW  = (DINWIDTH < DOUTWIDTH) ? DINWIDTH : DOUTWIDTH,
  localparam int LANES = DEPTH * DINWIDTH / MINW,
  localparam int LW    = $clog2(LANES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [DINWIDTH-1:0]  din,
  input  logic                 rd_en,
  output logic [DOUTWIDTH-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic                 prog_full,
  output logic [LW-1:0]        level,
  output logic                 overflow,
  output logic                 underflow
);

  localparam int MAXW = (DINWIDTH > DOUTWIDTH) ? DINWIDTH : DOUTWIDTH;
  localparam int WL   = DINWIDTH / MINW;
  localparam int RL   = DOUTWIDTH / MINW;
  localparam int PW   = $clog2(LANES);

  localparam logic [LW-1:0] WL_L     = LW'(WL);
  localparam logic [LW-1:0] RL_L     = LW'(RL);
  localparam logic [LW-1:0] FULL_AT  = LW'(LANES - WL + 1);
  localparam logic [LW-1:0] PFULL_AT = LW'(PROG_FULL_THRESH);

  if (MAXW % MINW != 0) begin : g_bad_ratio
    $error("fifo_gearbox: wider port width must be an integer multiple of the narrower");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_gearbox: DEPTH must be a power of two and at least 2");
  end
  if (RL > LANES) begin : g_bad_read
    $error("fifo_gearbox: storage cannot hold a single read word");
  end

  logic [MINW-1:0] mem [LANES];
  logic [PW-1:0]   wptr;
  logic [PW-1:0]   rptr;
  logic            wr_ok;
  logic            rd_ok;

  // Lane index arithmetic modulo LANES; LANES need not be a power of two when the ratio is not.
  function automatic logic [PW-1:0] lane_idx(input logic [PW-1:0] p, input int unsigned off);
    int unsigned s;
    s = p + off;
    if (s >= LANES) s = s - LANES;
    return s[PW-1:0];
  endfunction

  assign full      = (level >= FULL_AT);
  assign empty     = (level < RL_L);
  assign prog_full = (level >= PFULL_AT);
  assign wr_ok     = wr_en & ~full;
  assign rd_ok     = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) begin
      for (int i = 0; i < WL; i++) begin
        mem[lane_idx(wptr, i)] <= din[i*MINW +: MINW];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr_ok) wptr <= lane_idx(wptr, WL);
      if (rd_ok) rptr <= lane_idx(rptr, RL);
      if (wr_ok || rd_ok) level <= level + (wr_ok ? WL_L : '0) - (rd_ok ? RL_L : '0);
    end
  end

  always_comb begin
    dout = '0;
    if (!empty) begin
      for (int i = 0; i < RL; i++) begin
        dout[i*MINW +: MINW] = mem[lane_idx(rptr, i)];
      end
    end
  end

`ifdef FIFO_GEARBOX_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full)  overflow  <= 1'b1;
      if (rd_en && empty) underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/fifo_gearbox.md
FIFO_GEARBOX -- requirements
Module: fifo_gearbox

Interface
REQ-001 Parameter DINWIDTH, default 64, write word width in bits.
REQ-002 Parameter DOUTWIDTH, default 16, read word width in bits; the larger of DINWIDTH/DOUTWIDTH SHALL be an integer multiple of the smaller (elaboration error otherwise).
REQ-003 Parameter DEPTH, default 128, capacity in write words, power of two, >=2.
REQ-004 Parameter PROG_FULL_THRESH, default DEPTH*DINWIDTH/MINW-8, programmable-full level in lanes (MINW = min(DINWIDTH,DOUTWIDTH); LANES = DEPTH*DINWIDTH/MINW).
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  write request.
REQ-008 din  input  DINWIDTH  write data.
REQ-009 rd_en  input  1  read/pop request (FWFT).
REQ-010 dout  output  DOUTWIDTH  oldest read word, valid while empty=0.
REQ-011 full  output  1  fewer than DINWIDTH/MINW free lanes.
REQ-012 empty  output  1  fewer than DOUTWIDTH/MINW stored lanes.
REQ-013 prog_full  output  1  level >= PROG_FULL_THRESH.
REQ-014 level  output  clog2(LANES+1)  stored lane count.
REQ-015 overflow, underflow  output  1 each  sticky error flags (present only per REQ-032).

Function
REQ-016 Storage SHALL be a register/distributed array of LANES lanes of MINW bits with lane-granular write and read pointers wrapping modulo LANES.
REQ-017 Lane order little-endian: din[MINW-1:0] is the first lane written; dout[MINW-1:0] is the oldest lane read.
REQ-018 wr_en=1 and full=0 at an edge SHALL store DINWIDTH/MINW lanes and advance write pointer by that amount.
REQ-019 rd_en=1 and empty=0 at an edge SHALL pop DOUTWIDTH/MINW lanes and advance read pointer by that amount.
REQ-020 wr_en while full and rd_en while empty SHALL be ignored, no state change except REQ-032 flags.
REQ-021 Simultaneous accepted write and read in one cycle SHALL both take effect; level updates by (write lanes - read lanes).
REQ-022 FWFT: dout SHALL present the oldest DOUTWIDTH/MINW lanes combinationally from storage whenever empty=0; dout SHALL be all-zero while empty=1.
REQ-023 Write-to-read latency: data written at edge N SHALL make empty fall after edge N (visible cycle N+1) if it completes a read word.
REQ-024 Partial read word (upsizing, fewer than DOUTWIDTH/MINW lanes stored) SHALL keep empty=1; no flush mode.
REQ-025 full, empty, prog_full, level SHALL be registered or derived solely from registered level; no combinational path from wr_en/rd_en/din to any output.
REQ-026 Pointer wrap SHALL be seamless: a multi-lane access straddling index LANES-1 -> 0 stores/returns lanes in order.

Reset
REQ-027 rst=1 SHALL immediately clear pointers and level, without waiting for clk.
REQ-028 Reset values: empty=1, full=0, prog_full=0, level=0, dout=0, overflow=0, underflow=0.
REQ-029 Reset mid-operation SHALL discard all stored lanes; storage contents need not be cleared.
REQ-030 wr_en/rd_en asserted during rst SHALL be ignored; first accepted access is at the first edge after rst deasserts.

Configuration
REQ-031 Macro FIFO_GEARBOX_ERR_FLAGS_EN selects error-flag logic.
REQ-032 Defined: overflow SHALL set on wr_en&full, underflow on rd_en&empty, each sticky until rst; undefined: both ports SHALL be tied 0 and no flag registers inferred.

Verification
REQ-033 64->16, DEPTH=4: write 0x4444_3333_2222_1111 -> empty falls next cycle; four reads return 0x1111,0x2222,0x3333,0x4444, then empty=1, dout=0.
REQ-034 16->64: write 0xAAAA,0xBBBB,0xCCCC -> empty stays 1, level=3; write 0xDDDD -> dout=0xDDDD_CCCC_BBBB_AAAA next cycle.
REQ-035 64->16, DEPTH=4: four writes -> full=1, level=16; fifth write ignored, overflow=1 (macro defined) / 0 (undefined); contents intact.
REQ-036 Read and write each cycle for 100 cycles after offset start -> level constant, data in order across pointer wrap, no flag toggle.
REQ-037 rst pulsed for 3 ns between edges with level=10 -> outputs at REQ-028 values before next edge; subsequent write/read sequence correct.
REQ-038 Fill to PROG_FULL_THRESH-1 then one more write -> prog_full rises the following cycle; one read dropping below -> falls.
